vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing generator for the VGA output path. Divides the system clock down to the pixel rate. Runs the horizontal and vertical scan counters and produces the pixel coordinate, sync and blanking signals. Sits directly upstream of the combinational pixel-colour stages (square/sprite drawers), which consume `x`, `y` and `video_on`; `hsync`/`vsync` go straight to the connector.

## Interface
Parameters:
- `PIX_DIV`, 2, system clocks per pixel (≥1); 50 MHz → 25 MHz pixel rate
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of `hsync`/`vsync` (0 = active-low)

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `x` out 10: current horizontal count, 0..H_TOTAL-1
- `y` out 10: current vertical count, 0..V_TOTAL-1
- `video_on` out 1: high while x<H_ACTIVE and y<V_ACTIVE
- `hsync` out 1: horizontal sync, level per SYNC_POL
- `vsync` out 1: vertical sync, level per SYNC_POL
- `pixel_tick` out 1: high on the last clock of each pixel period
- `line_start` out 1: pixel_tick && x==0
- `frame_start` out 1: pixel_tick && x==0 && y==0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Elaboration error if either exceeds 1024 or PIX_DIV<1.
- Divider `div` counts 0..PIX_DIV-1 and wraps.
- `pixel_tick` is high in the cycle where div==PIX_DIV-1. With PIX_DIV=1 it is constantly high.
- On the edge ending a `pixel_tick` cycle, the horizontal counter advances:
  - x==H_TOTAL-1 → x=0 and y advances.
  - y==V_TOTAL-1 at that point → y=0.
  - Otherwise +1.
- Horizontal phases (ACTIVE → FRONT → SYNC → BACK → ACTIVE), decoded from x:
  - ACTIVE: x<H_ACTIVE
  - FRONT: x<H_ACTIVE+H_FP
  - SYNC: x<H_ACTIVE+H_FP+H_SYNC
  - BACK: otherwise
- Vertical phases are decoded identically from y.
- `hsync` is asserted (==SYNC_POL) in horizontal SYNC (x 656..751). `vsync` is asserted in vertical SYNC (y 490..491). Both are otherwise ==~SYNC_POL.
- All outputs come from flops and are updated on the same edge as the counters, from the next-state counter values. `x`, `y`, `video_on`, syncs and start strobes are therefore always mutually consistent, with no combinational glitches.

## Timing
- Reset (sampled high at an edge) forces:
  - div=0, x=0, y=0, video_on=0
  - hsync=vsync=~SYNC_POL
  - pixel_tick=line_start=frame_start=0
- Reset mid-frame aborts the scan immediately. No completion of the current line.
- First edge after reset release: outputs decode position (0,0).
  - video_on=1.
  - pixel_tick=1 if PIX_DIV==1; otherwise it first rises PIX_DIV-1 clocks later.
- Each (x,y) position is held for exactly PIX_DIV clocks.
- Line period = H_TOTAL×PIX_DIV clocks (1600). Frame period = V_TOTAL×H_TOTAL×PIX_DIV clocks (840000).
- `frame_start` pulses once per frame, one clock wide, coincident with `line_start`.
- Downstream colour stages are combinational on x/y. RGB is valid in the same cycle as the matching `video_on`; the downstream stage must blank when `video_on`=0.
- y changes only on the edge where x wraps to 0. Sync edges align with pixel boundaries.

## Test plan
- Reset check: hold reset 5 clocks → x=0, y=0, video_on=0, hsync=vsync=1, pixel_tick=0. Release → next cycle video_on=1; pixel_tick first high 1 clock later (PIX_DIV=2).
- Horizontal timing, default params, one line:
  - Exactly 1600 clocks between line_start pulses.
  - hsync low for exactly 192 clocks, starting at x=656.
  - video_on high for 1280 clocks, falling when x becomes 640.
- Vertical timing, one full frame:
  - frame_start interval 840000 clocks.
  - vsync low for lines 490–491 (3200 clocks).
  - 307200 pixel_ticks with video_on=1.
- Wrap-around: at x=799, y=524 the next pixel_tick edge → x=0, y=0, frame_start=1.
  - At x=799, y=10 → x=0, y=11, line_start=1, frame_start=0.
- Mid-frame reset: assert reset at x=300, y=200 for 1 clock → outputs at reset values. Scan restarts at (0,0); next frame_start 840000 clocks later.
- PIX_DIV=1, SYNC_POL=1:
  - pixel_tick constantly high.
  - Line period 800 clocks.
  - hsync high for x 656..751; vsync high for y 490..491.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v scan counters, and
// registered x/y, video_on, hsync/vsync, pixel_tick and start strobes.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   x, y        current scan position (10 bits each)
//   video_on    high inside the visible area
//   hsync/vsync sync outputs, asserted level = SYNC_POL
//   pixel_tick  high on the last system clock of each pixel period
//   line_start  pixel_tick at x==0
//   frame_start pixel_tick at x==0, y==0
module vga_timing_gen #(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       pixel_tick,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIX_DIV < 1) begin : g_param_err
        $error("vga_timing_gen: totals must be <= 1024 and PIX_DIV >= 1");
    end

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [9:0]    X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    Y_LAST   = 10'(V_TOTAL - 1);

    localparam logic [10:0] H_E_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_E_FP   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_E_SYNC = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_E_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] V_E_FP   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_E_SYNC = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    // Decode the scan phase of a counter against its three phase ends.
    function automatic phase_t phase_of(
        input logic [9:0]  c,
        input logic [10:0] e_act,
        input logic [10:0] e_fp,
        input logic [10:0] e_sync
    );
        logic [10:0] w;
        w = {1'b0, c};
        phase_of = PH_BACK;
        unique case (1'b1)
            (w < e_act):                  phase_of = PH_ACTIVE;
            (w >= e_act && w < e_fp):     phase_of = PH_FRONT;
            (w >= e_fp && w < e_sync):    phase_of = PH_SYNC;
            default:                      phase_of = PH_BACK;
        endcase
    endfunction

    logic [DW-1:0] div;
    logic [DW-1:0] div_n;
    logic [9:0]    x_n;
    logic [9:0]    y_n;
    logic          tick_n;
    logic          run;
    phase_t        hph_n;
    phase_t        vph_n;

    // run is low only on the first edge after reset: that edge parks the
    // scan at (0,0) with div=0 so each position still lasts PIX_DIV clocks.
    always_comb begin
        div_n = div;
        x_n   = x;
        y_n   = y;
        if (!run) begin
            div_n = '0;
            x_n   = '0;
            y_n   = '0;
        end else if (div == DIV_LAST) begin
            div_n = '0;
            if (x == X_LAST) begin
                x_n = '0;
                y_n = (y == Y_LAST) ? 10'd0 : y + 10'd1;
            end else begin
                x_n = x + 10'd1;
            end
        end else begin
            div_n = div + 1'b1;
        end
        tick_n = (div_n == DIV_LAST);
        hph_n  = phase_of(x_n, H_E_ACT, H_E_FP, H_E_SYNC);
        vph_n  = phase_of(y_n, V_E_ACT, V_E_FP, V_E_SYNC);
    end

    // Every output is decoded from next-state counters so all of them
    // change together on one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            run         <= 1'b0;
            div         <= '0;
            x           <= '0;
            y           <= '0;
            video_on    <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            pixel_tick  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            run         <= 1'b1;
            div         <= div_n;
            x           <= x_n;
            y           <= y_n;
            video_on    <= (hph_n == PH_ACTIVE) && (vph_n == PH_ACTIVE);
            hsync       <= (hph_n == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (vph_n == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            pixel_tick  <= tick_n;
            line_start  <= tick_n && (x_n == 10'd0);
            frame_start <= tick_n && (x_n == 10'd0) && (y_n == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench for vga_timing_gen: three configurations
// checked every clock against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        int pd;
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit pol;
    } cfg_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hs;
        logic       vs;
        logic       pt;
        logic       ls;
        logic       fs;
    } out_t;

    localparam cfg_t C0 = '{pd: 2, ha: 640, hf: 16, hs: 96, hb: 48,
                            va: 480, vf: 10, vs: 2, vb: 33, pol: 1'b0};
    localparam cfg_t C1 = '{pd: 1, ha: 20, hf: 3, hs: 5, hb: 4,
                            va: 12, vf: 2, vs: 3, vb: 4, pol: 1'b1};
    localparam cfg_t C2 = '{pd: 3, ha: 10, hf: 2, hs: 3, hb: 1,
                            va: 6, vf: 1, vs: 2, vb: 3, pol: 1'b0};

    logic       clk = 1'b0;
    logic       rst [3];
    logic [9:0] xo  [3];
    logic [9:0] yo  [3];
    logic       vono[3];
    logic       hso [3];
    logic       vso [3];
    logic       pto [3];
    logic       lso [3];
    logic       fso [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .PIX_DIV(C0.pd), .H_ACTIVE(C0.ha), .H_FP(C0.hf), .H_SYNC(C0.hs),
        .H_BP(C0.hb), .V_ACTIVE(C0.va), .V_FP(C0.vf), .V_SYNC(C0.vs),
        .V_BP(C0.vb), .SYNC_POL(C0.pol)
    ) dut0 (
        .clk(clk), .reset(rst[0]), .x(xo[0]), .y(yo[0]),
        .video_on(vono[0]), .hsync(hso[0]), .vsync(vso[0]),
        .pixel_tick(pto[0]), .line_start(lso[0]), .frame_start(fso[0])
    );

    vga_timing_gen #(
        .PIX_DIV(C1.pd), .H_ACTIVE(C1.ha), .H_FP(C1.hf), .H_SYNC(C1.hs),
        .H_BP(C1.hb), .V_ACTIVE(C1.va), .V_FP(C1.vf), .V_SYNC(C1.vs),
        .V_BP(C1.vb), .SYNC_POL(C1.pol)
    ) dut1 (
        .clk(clk), .reset(rst[1]), .x(xo[1]), .y(yo[1]),
        .video_on(vono[1]), .hsync(hso[1]), .vsync(vso[1]),
        .pixel_tick(pto[1]), .line_start(lso[1]), .frame_start(fso[1])
    );

    vga_timing_gen #(
        .PIX_DIV(C2.pd), .H_ACTIVE(C2.ha), .H_FP(C2.hf), .H_SYNC(C2.hs),
        .H_BP(C2.hb), .V_ACTIVE(C2.va), .V_FP(C2.vf), .V_SYNC(C2.vs),
        .V_BP(C2.vb), .SYNC_POL(C2.pol)
    ) dut2 (
        .clk(clk), .reset(rst[2]), .x(xo[2]), .y(yo[2]),
        .video_on(vono[2]), .hsync(hso[2]), .vsync(vso[2]),
        .pixel_tick(pto[2]), .line_start(lso[2]), .frame_start(fso[2])
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    function automatic cfg_t cfg_of(input int i);
        case (i)
            0:       return C0;
            1:       return C1;
            default: return C2;
        endcase
    endfunction

    function automatic int h_tot(input cfg_t c);
        return c.ha + c.hf + c.hs + c.hb;
    endfunction

    function automatic int v_tot(input cfg_t c);
        return c.va + c.vf + c.vs + c.vb;
    endfunction

    // n = clocks elapsed since the first edge after reset release.
    function automatic out_t model_out(input cfg_t c, input int n,
                                       input bit in_rst);
        out_t r;
        int   p, xx, yy;
        r = '0;
        if (in_rst) begin
            r.hs = ~c.pol;
            r.vs = ~c.pol;
            return r;
        end
        p  = n / c.pd;
        xx = p % h_tot(c);
        yy = (p / h_tot(c)) % v_tot(c);
        r.x   = 10'(xx);
        r.y   = 10'(yy);
        r.pt  = ((n % c.pd) == c.pd - 1);
        r.von = (xx < c.ha) && (yy < c.va);
        r.hs  = (xx >= c.ha + c.hf && xx < c.ha + c.hf + c.hs) ?
                c.pol : ~c.pol;
        r.vs  = (yy >= c.va + c.vf && yy < c.va + c.vf + c.vs) ?
                c.pol : ~c.pol;
        r.ls  = r.pt && (xx == 0);
        r.fs  = r.ls && (yy == 0);
        return r;
    endfunction

    int cnt   [3];
    bit mrst  [3];
    bit mvalid[3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                mrst[i]   <= 1'b1;
                mvalid[i] <= 1'b1;
            end else if (mrst[i]) begin
                mrst[i] <= 1'b0;
                cnt[i]  <= 0;
            end else begin
                cnt[i] <= cnt[i] + 1;
            end
        end
    end

    int   cyc = 0;
    int   last_ls[3];
    int   last_fs[3];
    int   act    [3];
    int   hs_run [3];
    int   vs_run [3];
    int   vo_run [3];
    bit   hs_p   [3];
    bit   vs_p   [3];
    bit   vo_p   [3];
    out_t g, e;
    cfg_t c;
    bit   hon, von;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (mvalid[i]) begin
                c = cfg_of(i);
                e = model_out(c, cnt[i], mrst[i]);
                g = {xo[i], yo[i], vono[i], hso[i], vso[i],
                     pto[i], lso[i], fso[i]};
                check($sformatf("d%0d.outputs", i), 64'(g), 64'(e));
                if (mrst[i]) begin
                    last_ls[i] = -1;
                    last_fs[i] = -1;
                    act[i]     = 0;
                    hs_run[i]  = 0;
                    vs_run[i]  = 0;
                    vo_run[i]  = 0;
                    hs_p[i]    = 1'b0;
                    vs_p[i]    = 1'b0;
                    vo_p[i]    = 1'b0;
                end else begin
                    if (g.ls) begin
                        if (last_ls[i] >= 0)
                            check($sformatf("d%0d.line_period", i),
                                  64'(cyc - last_ls[i]), 64'(h_tot(c) * c.pd));
                        last_ls[i] = cyc;
                    end
                    if (g.fs) begin
                        if (last_fs[i] >= 0) begin
                            check($sformatf("d%0d.frame_period", i),
                                  64'(cyc - last_fs[i]),
                                  64'(h_tot(c) * v_tot(c) * c.pd));
                            check($sformatf("d%0d.active_ticks", i),
                                  64'(act[i]), 64'(c.ha * c.va));
                        end
                        last_fs[i] = cyc;
                        act[i]     = 0;
                    end
                    if (g.pt && g.von) act[i]++;

                    hon = (g.hs == c.pol);
                    if (hon && !hs_p[i])
                        check($sformatf("d%0d.hsync_x", i),
                              64'(g.x), 64'(c.ha + c.hf));
                    if (!hon && hs_p[i])
                        check($sformatf("d%0d.hsync_len", i),
                              64'(hs_run[i]), 64'(c.hs * c.pd));
                    hs_run[i] = hon ? hs_run[i] + 1 : 0;
                    hs_p[i]   = hon;

                    von = (g.vs == c.pol);
                    if (von && !vs_p[i])
                        check($sformatf("d%0d.vsync_xy", i),
                              64'({g.x, g.y}), 64'({10'd0, 10'(c.va + c.vf)}));
                    if (!von && vs_p[i])
                        check($sformatf("d%0d.vsync_len", i), 64'(vs_run[i]),
                              64'(c.vs * h_tot(c) * c.pd));
                    vs_run[i] = von ? vs_run[i] + 1 : 0;
                    vs_p[i]   = von;

                    if (g.von && !vo_p[i])
                        check($sformatf("d%0d.video_rise_x", i),
                              64'(g.x), 64'd0);
                    if (!g.von && vo_p[i]) begin
                        check($sformatf("d%0d.video_len", i),
                              64'(vo_run[i]), 64'(c.ha * c.pd));
                        check($sformatf("d%0d.video_fall_x", i),
                              64'(g.x), 64'(c.ha));
                    end
                    vo_run[i] = g.von ? vo_run[i] + 1 : 0;
                    vo_p[i]   = g.von;
                end
            end
        end
    end

    task automatic wrap_check(input int yy, input int ey, input bit efs);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            if (int'(xo[1]) == h_tot(C1) - 1 && int'(yo[1]) == yy)
                found = 1'b1;
        end
        check($sformatf("wrap_y%0d.seen", yy), 64'(found), 64'd1);
        if (found) begin
            @(negedge clk);
            check($sformatf("wrap_y%0d.xy", yy),
                  64'({xo[1], yo[1]}), 64'({10'd0, 10'(ey)}));
            check($sformatf("wrap_y%0d.line_start", yy), 64'(lso[1]), 64'd1);
            check($sformatf("wrap_y%0d.frame_start", yy), 64'(fso[1]),
                  64'(efs));
        end
    endtask

    initial begin
        int which;
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        repeat (5) @(negedge clk);
        check("rst.x", 64'(xo[0]), 64'd0);
        check("rst.y", 64'(yo[0]), 64'd0);
        check("rst.video_on", 64'(vono[0]), 64'd0);
        check("rst.hsync", 64'(hso[0]), 64'd1);
        check("rst.vsync", 64'(vso[0]), 64'd1);
        check("rst.pixel_tick", 64'(pto[0]), 64'd0);
        check("rst.frame_start", 64'(fso[0]), 64'd0);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        @(negedge clk);
        check("rel.video_on", 64'(vono[0]), 64'd1);
        check("rel.pixel_tick", 64'(pto[0]), 64'd0);
        check("rel.pt_div1", 64'(pto[1]), 64'd1);
        @(negedge clk);
        check("rel2.pixel_tick", 64'(pto[0]), 64'd1);
        check("rel2.frame_start", 64'(fso[0]), 64'd1);
        check("rel2.xy", 64'({xo[0], yo[0]}), 64'd0);

        wrap_check(v_tot(C1) - 1, 0, 1'b1);
        wrap_check(5, 6, 1'b0);

        repeat (5000) @(negedge clk);

        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(4000, 20)) @(negedge clk);
            which = int'($urandom_range(2, 0));
            rst[which] = 1'b1;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            rst[which] = 1'b0;
        end

        repeat (4000) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
